// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer: opcodes, function-unit
// select codes, sequencer states and the decoded control word.
package cpu_ctrl_pkg;

  localparam logic [6:0] OP_MOVA = 7'b0000000;
  localparam logic [6:0] OP_ADD  = 7'b0000010;
  localparam logic [6:0] OP_ADI  = 7'b1000010;
  localparam logic [6:0] OP_LD   = 7'b0010000;
  localparam logic [6:0] OP_ST   = 7'b0100000;
  localparam logic [6:0] OP_BRZ  = 7'b1100000;
  localparam logic [6:0] OP_JMP  = 7'b1110000;
  localparam logic [6:0] OP_SRM  = 7'b0001101;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  localparam logic [3:0] FS_TFRA = 4'b0000;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_SHRB = 4'b1101;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    MEM   = 3'd2,
    SHIFT = 3'd3,
    HALT  = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0]  da;
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic        mb1;
    logic [15:0] cs11;
    logic [3:0]  fs;
    logic        md;
    logic        rw;
    logic        mw;
    logic        dmem_req;
    logic        imem_req;
    logic        illegal_op;
    logic        halted;
  } ctrl_t;

  // Branch offset is the 6-bit {DR, SB} field, sign-extended.
  function automatic logic [15:0] brz_offset(input logic [15:0] ir);
    return {{10{ir[8]}}, ir[8:6], ir[2:0]};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the instruction register and sequencer state into
// the datapath control word.
module instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [15:0] ir,
  input  logic        dmem_ready,
  output ctrl_t       ctrl
);

  logic [6:0] op;
  logic [2:0] dr;
  logic [2:0] sa;
  logic [2:0] sb;

  assign op = ir[15:9];
  assign dr = ir[8:6];
  assign sa = ir[5:3];
  assign sb = ir[2:0];

  always_comb begin
    ctrl      = '0;
    ctrl.da   = dr;
    ctrl.aa   = sa;
    ctrl.ba   = sb;
    ctrl.cs11 = {13'b0, sb};
    case (state)
      FETCH: ctrl.imem_req = 1'b1;
      EXEC: begin
        case (op)
          OP_MOVA: begin
            ctrl.fs = FS_TFRA;
            ctrl.rw = 1'b1;
          end
          OP_ADD: begin
            ctrl.fs = FS_ADD;
            ctrl.rw = 1'b1;
          end
          OP_ADI: begin
            ctrl.fs  = FS_ADD;
            ctrl.mb1 = 1'b1;
            ctrl.rw  = 1'b1;
          end
          OP_LD, OP_ST: ctrl.dmem_req = 1'b1;
          OP_BRZ: begin
            ctrl.fs   = FS_TFRA;
            ctrl.cs11 = brz_offset(ir);
          end
          OP_SRM: begin
            // First shift reads SA; subsequent SHIFT cycles re-read DR.
            if (sb != 3'd0) begin
              ctrl.fs = FS_SHRB;
              ctrl.ba = sa;
              ctrl.rw = 1'b1;
            end
          end
          OP_JMP, OP_HALT: ;
          default: ctrl.illegal_op = 1'b1;
        endcase
      end
      MEM: begin
        ctrl.dmem_req = 1'b1;
        if (dmem_ready) begin
          if (op == OP_LD) begin
            ctrl.md = 1'b1;
            ctrl.rw = 1'b1;
          end else begin
            ctrl.mw = 1'b1;
          end
        end
      end
      SHIFT: begin
        ctrl.fs = FS_SHRB;
        ctrl.ba = dr;
        ctrl.rw = 1'b1;
      end
      HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle control sequencer: owns state, PC, IR and the shift counter and
// presents the decoded control word to the 16-bit datapath.
module cpu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     instr_in,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  input  logic [15:0]     A_bus,
  input  logic            Z,
  output logic [PC_W-1:0] pc_out,
  output logic            imem_req,
  output logic            dmem_req,
  output logic [2:0]      DA,
  output logic [2:0]      AA,
  output logic [2:0]      BA,
  output logic            MB1,
  output logic [15:0]     CS11,
  output logic [3:0]      FS,
  output logic            MD,
  output logic            RW,
  output logic            MW,
  output logic            illegal_op,
  output logic            halted
);

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [15:0]     ir_reg;
  logic [2:0]      cnt_reg, cnt_next;
  logic            ir_load;
  logic [15:0]     offs;
  logic [6:0]      op;
  logic [2:0]      sb;
  logic            unused_bits;
  ctrl_t           ctrl;

  assign op   = ir_reg[15:9];
  assign sb   = ir_reg[2:0];
  assign offs = brz_offset(ir_reg);
  assign unused_bits = ^{A_bus, offs};

  instr_decoder u_decoder (
    .state      (state_reg),
    .ir         (ir_reg),
    .dmem_ready (dmem_ready),
    .ctrl       (ctrl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
      pc_reg    <= '0;
      ir_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
      if (ir_load) ir_reg <= instr_in;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    ir_load    = 1'b0;
    case (state_reg)
      FETCH: begin
        if (imem_ready) begin
          ir_load    = 1'b1;
          pc_next    = pc_reg + PC_W'(1);
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = FETCH;
        case (op)
          OP_LD, OP_ST: state_next = MEM;
          // PC already points past the branch, so the offset is relative to it.
          OP_BRZ: if (Z) pc_next = pc_reg + offs[PC_W-1:0];
          OP_JMP: pc_next = A_bus[PC_W-1:0];
          OP_SRM: begin
            if (sb != 3'd0) begin
              cnt_next = sb - 3'd1;
              if (sb > 3'd1) state_next = SHIFT;
            end
          end
          OP_HALT: state_next = HALT;
          default: ;
        endcase
      end
      MEM: if (dmem_ready) state_next = FETCH;
      SHIFT: begin
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg == 3'd1) state_next = FETCH;
      end
      HALT: ;
      default: state_next = FETCH;
    endcase
  end

  assign pc_out     = pc_reg;
  assign imem_req   = ctrl.imem_req;
  assign dmem_req   = ctrl.dmem_req;
  assign DA         = ctrl.da;
  assign AA         = ctrl.aa;
  assign BA         = ctrl.ba;
  assign MB1        = ctrl.mb1;
  assign CS11       = ctrl.cs11;
  assign FS         = ctrl.fs;
  assign MD         = ctrl.md;
  assign RW         = ctrl.rw;
  assign MW         = ctrl.mw;
  assign illegal_op = ctrl.illegal_op;
  assign halted     = ctrl.halted;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Scoreboard bench: an instruction-level model queues expected fetches and
// register/memory writes; a negedge monitor pops and compares them.
module tb_cpu_control_sequencer;

  localparam logic [6:0] T_MOVA = 7'b0000000;
  localparam logic [6:0] T_ADD  = 7'b0000010;
  localparam logic [6:0] T_ADI  = 7'b1000010;
  localparam logic [6:0] T_LD   = 7'b0010000;
  localparam logic [6:0] T_ST   = 7'b0100000;
  localparam logic [6:0] T_BRZ  = 7'b1100000;
  localparam logic [6:0] T_JMP  = 7'b1110000;
  localparam logic [6:0] T_SRM  = 7'b0001101;
  localparam logic [6:0] T_HALT = 7'b1111111;

  localparam int K_FETCH = 0;
  localparam int K_RW    = 1;
  localparam int K_MW    = 2;
  localparam int K_ILL   = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr_in;
  logic        imem_ready;
  logic        dmem_ready;
  logic [15:0] A_bus;
  logic        Z;
  logic [7:0]  pc_out;
  logic        imem_req, dmem_req;
  logic [2:0]  DA, AA, BA;
  logic        MB1;
  logic [15:0] CS11;
  logic [3:0]  FS;
  logic        MD, RW, MW, illegal_op, halted;

  cpu_control_sequencer #(.PC_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_in   (instr_in),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .A_bus      (A_bus),
    .Z          (Z),
    .pc_out     (pc_out),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .DA         (DA),
    .AA         (AA),
    .BA         (BA),
    .MB1        (MB1),
    .CS11       (CS11),
    .FS         (FS),
    .MD         (MD),
    .RW         (RW),
    .MW         (MW),
    .illegal_op (illegal_op),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [7:0]  pc;
    logic [2:0]  da, aa, ba;
    logic [3:0]  fs;
    bit          chk_fs;
    logic        mb1;
    bit          chk_mb1;
    logic [15:0] cs11;
    logic        md;
  } ev_t;

  ev_t        exp_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] m_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void push(input int kind, input logic [2:0] da, input logic [2:0] aa,
                               input logic [2:0] ba, input logic [3:0] fs, input bit chk_fs,
                               input logic mb1, input bit chk_mb1, input logic [15:0] cs11,
                               input logic md);
    ev_t e;
    e.kind = kind; e.pc = m_pc; e.da = da; e.aa = aa; e.ba = ba;
    e.fs = fs; e.chk_fs = chk_fs; e.mb1 = mb1; e.chk_mb1 = chk_mb1;
    e.cs11 = cs11; e.md = md;
    exp_q.push_back(e);
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {T_MOVA, T_ADD, T_ADI, T_LD, T_ST, T_BRZ, T_JMP, T_SRM, T_HALT};
  endfunction

  // Monitor: every fetch handshake, register write, memory write or illegal pulse
  // is one observed transaction.
  always @(negedge clk) begin
    int  k;
    ev_t e;
    if (rst_n) begin
      k = -1;
      if (imem_req && imem_ready) k = K_FETCH;
      else if (RW)                k = K_RW;
      else if (MW)                k = K_MW;
      else if (illegal_op)        k = K_ILL;
      if (k >= 0) begin
        $display("[TB] txn kind=%0d pc=%02h DA=%0d AA=%0d BA=%0d FS=%h MB1=%0d CS11=%04h MD=%0d",
                 k, pc_out, DA, AA, BA, FS, MB1, CS11, MD);
        if (exp_q.size() == 0) begin
          chk("unexpected_txn", 32'(k), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("txn_kind", 32'(k), 32'(e.kind));
          if (e.kind == K_FETCH) begin
            chk("fetch_pc", 32'(pc_out), 32'(e.pc));
          end else if (e.kind == K_ILL) begin
            chk("illegal_no_write", 32'(RW | MW), 32'd0);
          end else begin
            chk("da", 32'(DA), 32'(e.da));
            chk("aa", 32'(AA), 32'(e.aa));
            chk("ba", 32'(BA), 32'(e.ba));
            if (e.kind == K_RW) begin
              chk("md", 32'(MD), 32'(e.md));
              chk("rw_mw_excl", 32'(MW), 32'd0);
            end else begin
              chk("mw_rw_excl", 32'(RW), 32'd0);
            end
            if (e.chk_fs) chk("fs", 32'(FS), 32'(e.fs));
            if (e.chk_mb1) begin
              chk("mb1", 32'(MB1), 32'(e.mb1));
              if (e.mb1) chk("cs11", 32'(CS11), 32'(e.cs11));
            end
          end
        end
      end
    end
  end

  // Present one instruction once the sequencer asks for it; returns in EXEC.
  task automatic do_fetch(input logic [15:0] ins, input logic z, input logic [15:0] a, input int dly);
    int n = 0;
    while (!imem_req && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (!imem_req) chk("imem_req_timeout", 32'd0, 32'd1);
    repeat (dly) begin
      @(posedge clk); #1;
    end
    instr_in = ins; Z = z; A_bus = a; imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    instr_in = 16'($urandom);
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic z, input logic [15:0] a,
                           input int dly, input int mem_wait, input logic early_rdy);
    logic [6:0]  op;
    logic [2:0]  dr, sa, sb;
    logic [15:0] sext;
    int          off, nreq;
    op = ins[15:9]; dr = ins[8:6]; sa = ins[5:3]; sb = ins[2:0];
    off = int'({dr, sb});
    if (off >= 32) off -= 64;
    sext = 16'(off);
    push(K_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_pc = m_pc + 8'd1;
    case (op)
      T_MOVA: push(K_RW, dr, sa, sb, 4'h0, 1, 0, 0, 0, 0);
      T_ADD:  push(K_RW, dr, sa, sb, 4'h2, 1, 0, 1, 0, 0);
      T_ADI:  push(K_RW, dr, sa, sb, 4'h2, 1, 1, 1, {13'b0, sb}, 0);
      T_LD:   push(K_RW, dr, sa, sb, 4'h0, 0, 0, 0, 0, 1);
      T_ST:   push(K_MW, dr, sa, sb, 4'h0, 0, 0, 0, 0, 0);
      T_BRZ:  if (z) m_pc = 8'(int'(m_pc) + off);
      T_JMP:  m_pc = a[7:0];
      T_SRM:  for (int i = 0; i < int'(sb); i++)
                push(K_RW, dr, sa, (i == 0) ? sa : dr, 4'hD, 1, 0, 0, 0, 0);
      T_HALT: ;
      default: push(K_ILL, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endcase
    do_fetch(ins, z, a, dly);
    if (op == T_BRZ) begin
      chk("brz_cs11", 32'(CS11), 32'(sext));
      chk("brz_fs", 32'(FS), 32'd0);
    end
    if (op == T_LD || op == T_ST) begin
      nreq = 0;
      dmem_ready = early_rdy;
      if (dmem_req) nreq++;
      @(posedge clk); #1;
      dmem_ready = 1'b0;
      for (int i = 0; i < mem_wait; i++) begin
        if (dmem_req) nreq++;
        @(posedge clk); #1;
      end
      dmem_ready = 1'b1;
      if (dmem_req) nreq++;
      @(posedge clk); #1;
      dmem_ready = 1'b0;
      chk("dmem_req_cycles", 32'(nreq), 32'(mem_wait + 2));
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [6:0] op;
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: op = T_MOVA;
      1: op = T_ADD;
      2: op = T_ADI;
      3: op = T_LD;
      4: op = T_ST;
      5: op = T_BRZ;
      6: op = T_JMP;
      7, 8: op = T_SRM;
      default: begin
        op = 7'($urandom_range(0, 127));
        while (is_legal(op)) op = 7'($urandom_range(0, 127));
      end
    endcase
    return {op, 9'($urandom)};
  endfunction

  initial begin
    logic [15:0] ins;
    rst_n = 1'b0; instr_in = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    A_bus = '0; Z = 1'b0; m_pc = 8'h00;
    #12;
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd1);
    chk("rst_enables", 32'({dmem_req, MB1, MD, RW, MW, illegal_op, halted}), 32'd0);
    chk("rst_fields", 32'({DA, AA, BA, FS}), 32'd0);
    chk("rst_cs11", 32'(CS11), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr({T_ADI, 3'd1, 3'd2, 3'd5}, 0, 16'h0, 3, 0, 0);
    run_instr({T_LD, 3'd3, 3'd4, 3'd1}, 0, 16'h0, 0, 3, 0);
    run_instr({T_ST, 3'd6, 3'd5, 3'd7}, 0, 16'h0, 1, 0, 1);
    run_instr({T_SRM, 3'd2, 3'd2, 3'd3}, 0, 16'h0, 0, 0, 0);
    run_instr({T_MOVA, 3'd4, 3'd6, 3'd0}, 0, 16'h0, 0, 0, 0);
    run_instr({T_ADD, 3'd7, 3'd1, 3'd3}, 0, 16'h0, 2, 0, 0);
    run_instr({T_JMP, 9'd0}, 0, 16'h000A, 0, 0, 0);
    run_instr({T_BRZ, 3'b111, 3'd0, 3'b110}, 1, 16'h0, 0, 0, 0);
    run_instr({T_JMP, 9'd0}, 0, 16'h000A, 0, 0, 0);
    run_instr({T_BRZ, 3'b111, 3'd0, 3'b110}, 0, 16'h0, 0, 0, 0);
    run_instr({7'b0000111, 9'h1FF}, 0, 16'h0, 0, 0, 0);
    run_instr({T_SRM, 3'd5, 3'd1, 3'd0}, 0, 16'h0, 0, 0, 0);
    run_instr({T_SRM, 3'd5, 3'd1, 3'd1}, 0, 16'h0, 0, 0, 0);
    run_instr({T_MOVA, 3'd1, 3'd1, 3'd1}, 0, 16'h0, 0, 0, 0);

    for (int i = 0; i < 80; i++) begin
      run_instr(rand_instr(), 1'($urandom), 16'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 3), 1'($urandom));
    end

    run_instr({T_JMP, 9'd0}, 0, 16'h00FF, 0, 0, 0);
    run_instr({T_MOVA, 3'd2, 3'd3, 3'd4}, 0, 16'h0, 0, 0, 0);
    run_instr({T_MOVA, 3'd3, 3'd4, 3'd5}, 0, 16'h0, 0, 0, 0);

    // Reset while SHIFT has count 2 must kill the pending write immediately.
    ins = {T_SRM, 3'd2, 3'd2, 3'd3};
    push(K_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_pc = m_pc + 8'd1;
    push(K_RW, 3'd2, 3'd2, 3'd2, 4'hD, 1, 0, 0, 0, 0);
    do_fetch(ins, 0, 16'h0, 0);
    @(posedge clk); #1;
    chk("shift_rw_before_rst", 32'(RW), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_rw", 32'(RW), 32'd0);
    chk("abort_pc", 32'(pc_out), 32'd0);
    chk("abort_imem_req", 32'(imem_req), 32'd1);
    chk("abort_queue", 32'(exp_q.size()), 32'd0);
    m_pc = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr({T_ADI, 3'd6, 3'd7, 3'd2}, 0, 16'h0, 1, 0, 0);
    run_instr({T_HALT, 9'd0}, 0, 16'h0, 0, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      chk("halted", 32'(halted), 32'd1);
      chk("halt_quiet", 32'({imem_req, dmem_req, RW, MW}), 32'd0);
      chk("halt_pc", 32'(pc_out), 32'(m_pc));
      @(posedge clk); #1;
    end
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_control_sequencer.md
Name: cpu_control_sequencer

Overview:
Multi-cycle control sequencer for the 16-bit RISC datapath. Fetches instructions, decodes them, and drives the register-file addresses, the B-bus mux select (MB1) with its constant, the function-unit select and the memory handshakes. It sequences multi-cycle operations (loads/stores with wait states, shift-multiple) and owns the PC.

Parameters:
PC_W, 8, program counter width; PC wraps modulo 2^PC_W.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
instr_in  in  16  instruction word from instruction memory.
imem_ready  in  1  instruction memory has valid instr_in.
dmem_ready  in  1  data memory access complete.
A_bus  in  16  datapath A bus (JMP target).
Z  in  1  zero status from the function unit for the current operation.
pc_out  out  PC_W  current PC, used as instruction address.
imem_req  out  1  instruction fetch request.
dmem_req  out  1  data memory request.
DA, AA, BA  out  3 each  destination, A and B register addresses.
MB1  out  1  B-bus select: 0 = register B data, 1 = constant.
CS11  out  16  constant driven onto the B bus when MB1 = 1.
FS  out  4  function select.
MD  out  1  write-back select: 0 = function unit, 1 = memory.
RW  out  1  register write enable.
MW  out  1  memory write enable.
illegal_op  out  1  one-cycle pulse on an undefined opcode.
halted  out  1  high in HALT.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = FETCH; PC = 0; IR = 0; shift counter = 0.
  - All outputs are 0, except imem_req, which is 1 because the state is FETCH.
- IR fields: OP = IR[15:9], DR = IR[8:6], SA = IR[5:3], SB = IR[2:0].
- Constants: CS11 = zero-extended SB, except for BRZ, which uses the sign-extended 6-bit {DR, SB}.
- Control outputs (DA, AA, BA, MB1, FS, MD, CS11, RW, MW, dmem_req) are combinational from state, IR and counter.
- Default control values: DA = DR, AA = SA, BA = SB; all enables are 0.
- FETCH:
  - imem_req = 1.
  - When imem_ready = 1: IR <= instr_in, PC <= PC + 1, next state EXEC.
  - Otherwise the state holds.
- EXEC (one cycle unless noted):
  - MOVA 0000000: FS = 0000, RW = 1.
  - ADD 0000010: FS = 0010, MB1 = 0, RW = 1.
  - ADI 1000010: FS = 0010, MB1 = 1, RW = 1.
  - LD 0010000: dmem_req = 1, then go to MEM.
  - ST 0100000: dmem_req = 1, then go to MEM.
  - BRZ 1100000: FS = 0000, AA = SA. If Z = 1, PC <= PC + sext({DR, SB}), using the already-incremented PC.
  - JMP 1110000: PC <= A_bus[PC_W-1:0].
  - SRM 0001101:
    - If SB = 0: no-op, return to FETCH.
    - Otherwise: FS = 1101 (shift right B), BA = SA, RW = 1, counter <= SB - 1, then go to SHIFT if SB > 1, else FETCH.
  - HALT 1111111: go to HALT.
  - Any other opcode: illegal_op = 1 for this cycle, no writes, return to FETCH.
- MEM:
  - dmem_req = 1 and AA = SA are held until dmem_ready = 1.
  - For LD, MD = 1 and RW = 1 are asserted only in the dmem_ready cycle.
  - For ST, MW = 1 is asserted only in the dmem_ready cycle.
  - The state returns to FETCH after the dmem_ready cycle.
  - If dmem_ready is already 1 in EXEC, it is ignored; the access completes in MEM.
- SHIFT:
  - FS = 1101, BA = DR, DA = DR, RW = 1.
  - counter decrements each cycle; the state exits to FETCH in the cycle the counter equals 1.
  - SRM with count n therefore takes 1 + (n - 1) execute cycles, with exactly n RW pulses.
- HALT: all enables are 0 and halted = 1; only reset exits.
- PC wrap: 2^PC_W - 1 increments to 0, and branch arithmetic is modulo 2^PC_W.
- Reset asserted mid-operation (MEM or SHIFT) aborts immediately and returns to the reset values; no partial RW or MW pulse appears.
- Exactly one of RW or MW may be high in any cycle.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the opcode localparams (OP_MOVA … OP_HALT);
  - the FS codes (FS_TFRA = 0000, FS_ADD = 0010, FS_SHRB = 1101);
  - the state encoding (FETCH, EXEC, MEM, SHIFT, HALT).
- One natural sub-module, instr_decoder: combinational, maps IR and state to the control word. The sequencer keeps the state, PC, IR and counter.

Test Plan:
- Reset, then imem_ready held 0 for 3 cycles, then instr ADI DR=1, SA=2, SB=5 → PC 0→1; in the EXEC cycle MB1 = 1, CS11 = 0x0005, FS = 0010, DA = 1, AA = 2, RW = 1.
- LD DR=3, SA=4 with dmem_ready delayed 4 cycles → dmem_req high for 5 cycles (EXEC + 4 MEM), and MD = 1, RW = 1 only in the ready cycle.
- SRM DR=2, SA=2, SB=3 → 3 consecutive RW pulses with FS = 1101; first cycle BA = 2 from SA, then BA = DR; FETCH on the 4th cycle.
- BRZ with PC = 0x0A, offset {DR, SB} = 6'b111110 (-2), Z = 1 → next PC = 0x09. The same with Z = 0 → PC = 0x0B.
- Opcode 0000111 → illegal_op pulses once with no RW or MW. HALT opcode → halted = 1 and held for 20 cycles.
- rst_n asserted during SHIFT with counter = 2 → immediate FETCH, PC = 0, RW = 0 in the same cycle. Separately, fetch at PC = 0xFF → PC wraps to 0x00.
